// File: rtl/pingpong_unified_buffer_pkg.sv
// Shared definitions for the ping-pong unified buffer: bank identifiers and
// the helpers that derive address and byte-lane widths from the RAM geometry.
package pingpong_unified_buffer_pkg;

    localparam logic BANK0 = 1'b0;
    localparam logic BANK1 = 1'b1;

    // Number of bits needed to represent 'value' (0 for value == 0).
    function automatic int clogb2(input int value);
        int r;
        int v;
        v = value;
        for (r = 0; v > 0; r++) begin
            v = v >> 1;
        end
        return r;
    endfunction

    function automatic int num_bytes(input int width, input int byte_w);
        return width / byte_w;
    endfunction

    // Address width for a bank of 'depth' entries; never narrower than 1 bit.
    function automatic int addr_width(input int depth);
        return (depth > 1) ? clogb2(depth - 1) : 1;
    endfunction

endpackage

// File: rtl/pingpong_unified_buffer_sdp_bram_be.sv
// One bank of the ping-pong buffer: simple dual-port RAM with per-byte write
// enables and a registered read port. All updates happen on the falling edge.
module sdp_bram_be
    import pingpong_unified_buffer_pkg::*;
#(
    parameter int  RAM_WIDTH  = 128,
    parameter int  RAM_DEPTH  = 256,
    parameter int  BYTE_WIDTH = 8,
    localparam int NUM_BYTES  = num_bytes(RAM_WIDTH, BYTE_WIDTH),
    localparam int ADDR_W     = addr_width(RAM_DEPTH)
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic [NUM_BYTES-1:0] wea,
    input  logic [ADDR_W-1:0]    addra,
    input  logic [RAM_WIDTH-1:0] dina,
    input  logic                 enb,
    input  logic [ADDR_W-1:0]    addrb,
    output logic [RAM_WIDTH-1:0] doutb
);

    logic [RAM_WIDTH-1:0] mem [RAM_DEPTH];

    // Byte-lane write; addresses past the end of a non-power-of-2 bank are dropped.
    always_ff @(negedge clk) begin
        if (int'(addra) < RAM_DEPTH) begin
            for (int i = 0; i < NUM_BYTES; i++) begin
                if (wea[i]) begin
                    mem[addra][i*BYTE_WIDTH +: BYTE_WIDTH] <= dina[i*BYTE_WIDTH +: BYTE_WIDTH];
                end
            end
        end
    end

    // Registered read; the register only moves on an enabled read so it holds otherwise.
    always_ff @(negedge clk or negedge reset_n) begin
        if (!reset_n) begin
            doutb <= '0;
        end else if (enb) begin
            doutb <= mem[addrb];
        end
    end

endmodule

// File: rtl/pingpong_unified_buffer.sv
// Double-buffered on-chip buffer: the writer fills one bank while the reader
// drains the other, with commit/release handing banks across. Holds the bank
// pointers, full flags, sticky protocol error and the read output pipeline.
module pingpong_unified_buffer
    import pingpong_unified_buffer_pkg::*;
#(
    parameter int  RAM_WIDTH    = 128,
    parameter int  RAM_DEPTH    = 256,
    parameter int  BYTE_WIDTH   = 8,
    parameter int  READ_LATENCY = 1,
    localparam int NUM_BYTES    = num_bytes(RAM_WIDTH, BYTE_WIDTH),
    localparam int ADDR_W       = addr_width(RAM_DEPTH)
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic [NUM_BYTES-1:0] wea,
    input  logic [ADDR_W-1:0]    addra,
    input  logic [RAM_WIDTH-1:0] dina,
    input  logic                 wr_commit,
    output logic                 wr_ready,
    input  logic                 enb,
    input  logic [ADDR_W-1:0]    addrb,
    input  logic                 rd_release,
    output logic                 rd_ready,
    output logic [RAM_WIDTH-1:0] doutb,
    output logic                 doutb_valid,
    output logic                 err
);

    logic                 wr_bank;
    logic                 rd_bank;
    logic [1:0]           full;
    logic                 rd_acc;
    logic                 proto_err;
    logic [NUM_BYTES-1:0] wea0, wea1;
    logic                 enb0, enb1;
    logic [RAM_WIDTH-1:0] dout0, dout1;
    logic                 sel_p0;
    logic                 vld_p0;
    logic [RAM_WIDTH-1:0] doutb_p0;

    assign wr_ready = !full[wr_bank];
    assign rd_ready = full[rd_bank];
    assign rd_acc   = enb && rd_ready;

    // Any request against a bank that is not in the right state is dropped and flagged.
    assign proto_err = ((|wea) && !wr_ready) || (wr_commit && !wr_ready) ||
                       (enb && !rd_ready)    || (rd_release && !rd_ready);

    assign wea0 = (wr_ready && wr_bank == BANK0) ? wea : '0;
    assign wea1 = (wr_ready && wr_bank == BANK1) ? wea : '0;
    assign enb0 = rd_acc && (rd_bank == BANK0);
    assign enb1 = rd_acc && (rd_bank == BANK1);

    sdp_bram_be #(
        .RAM_WIDTH (RAM_WIDTH),
        .RAM_DEPTH (RAM_DEPTH),
        .BYTE_WIDTH(BYTE_WIDTH)
    ) u_bank0 (
        .clk    (clk),
        .reset_n(reset_n),
        .wea    (wea0),
        .addra  (addra),
        .dina   (dina),
        .enb    (enb0),
        .addrb  (addrb),
        .doutb  (dout0)
    );

    sdp_bram_be #(
        .RAM_WIDTH (RAM_WIDTH),
        .RAM_DEPTH (RAM_DEPTH),
        .BYTE_WIDTH(BYTE_WIDTH)
    ) u_bank1 (
        .clk    (clk),
        .reset_n(reset_n),
        .wea    (wea1),
        .addra  (addra),
        .dina   (dina),
        .enb    (enb1),
        .addrb  (addrb),
        .doutb  (dout1)
    );

    // Bank hand-over: commit and release act on different banks, so both may fire together.
    always_ff @(negedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_bank <= BANK0;
            rd_bank <= BANK0;
            full    <= '0;
            err     <= 1'b0;
        end else begin
            if (wr_commit && wr_ready) begin
                full[wr_bank] <= 1'b1;
                wr_bank       <= ~wr_bank;
            end
            if (rd_release && rd_ready) begin
                full[rd_bank] <= 1'b0;
                rd_bank       <= ~rd_bank;
            end
            if (proto_err) begin
                err <= 1'b1;
            end
        end
    end

    // Stage p0: remember which bank the RAM register was loaded from, aligned to the RAM read.
    always_ff @(negedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sel_p0 <= BANK0;
            vld_p0 <= 1'b0;
        end else begin
            vld_p0 <= rd_acc;
            if (rd_acc) begin
                sel_p0 <= rd_bank;
            end
        end
    end

    assign doutb_p0 = (sel_p0 == BANK1) ? dout1 : dout0;

    generate
        if (READ_LATENCY == 2) begin : g_lat2
            logic [RAM_WIDTH-1:0] doutb_p1;
            logic                 vld_p1;

            // Stage p1: extra output register; data only advances with a valid beat.
            always_ff @(negedge clk or negedge reset_n) begin
                if (!reset_n) begin
                    doutb_p1 <= '0;
                    vld_p1   <= 1'b0;
                end else begin
                    vld_p1 <= vld_p0;
                    if (vld_p0) begin
                        doutb_p1 <= doutb_p0;
                    end
                end
            end

            assign doutb       = doutb_p1;
            assign doutb_valid = vld_p1;
        end else begin : g_lat1
            assign doutb       = doutb_p0;
            assign doutb_valid = vld_p0;
        end
    endgenerate

endmodule
